// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - Register offsets of the memory-mapped block (byte offsets).
//   - Bit positions inside the STATUS word.
//   - Receive FSM state encoding.
//   - 8N1 frame constants.
package uart_pkg;

    // Register offsets; only bits [3:2] take part in the decode.
    localparam logic [3:0] REG_DATA = 4'h0;
    localparam logic [3:0] REG_STAT = 4'h4;

    // STATUS word layout.
    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVR       = 2;
    localparam int STAT_FERR      = 3;
    localparam int STAT_LEVEL_LSB = 8;

    // 8N1 framing.
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used to buffer received bytes.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset (pointers only)
//   push, push_data  write request and data; a push on a full FIFO is
//                    accepted only when a pop happens in the same cycle
//   pop              read request; ignored when empty
//   head             entry at the read pointer (valid when !empty)
//   full, empty      derived from the extra pointer MSB
//   level            number of stored entries, 0..2**AW
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             pop_en;
    logic             push_en;

    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level  = wr_ptr_reg - rd_ptr_reg;

    // A simultaneous pop frees the slot the push needs, so a full FIFO
    // still accepts the push in that cycle.
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);

    // Storage carries no reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    assign head = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// UART 8N1 receiver with receive FIFO and a native memory-bus responder.
// Ports:
//   clk, resetn   system clock, asynchronous active-low reset
//   uart_rx       serial input (asynchronous, idle high)
//   mem_valid     request, already address-qualified by the top level
//   mem_addr      byte offset; bits [3:2] select DATA/STATUS/unused
//   mem_wdata     write data (STATUS W1C bits 2 and 3)
//   mem_wstrb     byte strobes; nonzero means write
//   mem_ready     one-cycle completion pulse, one cycle after mem_valid
//   mem_rdata     read data, zero whenever mem_ready is low
//   rx_irq        registered "FIFO not empty"
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_rx,
    input  logic        mem_valid,
    input  logic [3:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        rx_irq
);
    localparam int CNT_W       = $clog2(CLKS_PER_BIT);
    localparam int IDX_W       = $clog2(DATA_BITS);
    localparam int SYNC_STAGES = 2;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchronizer, reset to the idle (high) line level.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic stage_in;
            if (gi == 0) begin : g_first
                assign stage_in = uart_rx;
            end else begin : g_chain
                assign stage_in = sync_reg[gi-1];
            end
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    sync_reg[gi] <= 1'b1;
                end else begin
                    sync_reg[gi] <= stage_in;
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t              state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [DATA_BITS-1:0]   shreg_reg, shreg_next;
    logic                   rx_push;
    logic                   ferr_set;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= RX_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shreg_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shreg_reg <= shreg_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shreg_next = shreg_reg;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                // Half a bit to land in the middle of the start bit.
                if (!rx_s) begin
                    state_next = RX_START;
                    cnt_next   = CNT_HALF;
                end
            end
            RX_START: begin
                if (cnt_reg == '0) begin
                    if (!rx_s) begin
                        state_next = RX_DATA;
                        cnt_next   = CNT_FULL;
                        idx_next   = '0;
                    end else begin
                        // Line went back high: a glitch, not a frame.
                        state_next = RX_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_reg == '0) begin
                    shreg_next = {rx_s, shreg_reg[DATA_BITS-1:1]};
                    cnt_next   = CNT_FULL;
                    idx_next   = idx_reg + 1'b1;
                    if (idx_reg == IDX_LAST) begin
                        state_next = RX_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_reg == '0) begin
                    if (rx_s) begin
                        rx_push    = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                // A held-low line (break) must not restart reception.
                if (rx_s) begin
                    state_next = RX_IDLE;
                end
            end
            default: begin
                state_next = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic                 fifo_pop;
    logic [7:0]           fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FIFO_AW:0]     fifo_level;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rx_push),
        .push_data (shreg_reg),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // ------------------------------------------------------------------
    // Bus decode, sticky flags and response
    // ------------------------------------------------------------------
    logic        mem_ready_reg;
    logic [31:0] mem_rdata_reg, rdata_next;
    logic        ovr_reg, ovr_next;
    logic        ferr_reg, ferr_next;
    logic        rx_irq_reg;
    logic        req;
    logic        is_wr;
    logic [1:0]  reg_sel;
    logic        stat_wr;
    logic        ovr_set;
    logic [31:0] status_word;

    // A request is serviced only in the cycle before the ready pulse,
    // so each transfer causes at most one pop or one W1C.
    assign req     = mem_valid & ~mem_ready_reg;
    assign is_wr   = |mem_wstrb;
    assign reg_sel = mem_addr[3:2];

    assign fifo_pop = req & ~is_wr & (reg_sel == REG_DATA[3:2]) & ~fifo_empty;
    assign stat_wr  = req & mem_wstrb[0] & (reg_sel == REG_STAT[3:2]);

    // Overrun only when the push is really refused.
    assign ovr_set   = rx_push & fifo_full & ~fifo_pop;
    assign ovr_next  = ovr_set  | (ovr_reg  & ~(stat_wr & mem_wdata[STAT_OVR]));
    assign ferr_next = ferr_set | (ferr_reg & ~(stat_wr & mem_wdata[STAT_FERR]));

    always_comb begin
        status_word = '0;
        status_word[STAT_NOT_EMPTY] = ~fifo_empty;
        status_word[STAT_FULL]      = fifo_full;
        status_word[STAT_OVR]       = ovr_reg;
        status_word[STAT_FERR]      = ferr_reg;
        status_word[STAT_LEVEL_LSB +: FIFO_AW+1] = fifo_level;
    end

    always_comb begin
        rdata_next = '0;
        if (!is_wr) begin
            if (reg_sel == REG_DATA[3:2]) begin
                if (!fifo_empty) begin
                    rdata_next = {23'b0, 1'b1, fifo_head};
                end
            end else if (reg_sel == REG_STAT[3:2]) begin
                rdata_next = status_word;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready_reg <= 1'b0;
            mem_rdata_reg <= '0;
            ovr_reg       <= 1'b0;
            ferr_reg      <= 1'b0;
            rx_irq_reg    <= 1'b0;
        end else begin
            ovr_reg    <= ovr_next;
            ferr_reg   <= ferr_next;
            rx_irq_reg <= ~fifo_empty;
            if (req) begin
                mem_ready_reg <= 1'b1;
                mem_rdata_reg <= rdata_next;
            end else begin
                mem_ready_reg <= 1'b0;
                mem_rdata_reg <= '0;
            end
        end
    end

    assign mem_ready = mem_ready_reg;
    assign mem_rdata = mem_rdata_reg;
    assign rx_irq    = rx_irq_reg;

    // Address LSBs and the non-W1C write bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = &{1'b0, mem_addr[1:0], mem_wdata[31:4], mem_wdata[1:0],
                           mem_wstrb[3:1], STOP_BITS[0]};

endmodule

// File: tb/tb_uart_rx_mmio.sv
module tb_uart_rx_mmio;
    localparam int CPB   = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        uart_rx = 1'b1;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        rx_irq;

    int total = 0;
    int bad = 0;

    // Reference model: received bytes in order plus the two sticky flags.
    logic [7:0] model_q[$];
    bit         m_ovr = 0;
    bit         m_ferr = 0;

    always #5 clk = ~clk;

    uart_rx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .uart_rx   (uart_rx),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .rx_irq    (rx_irq)
    );

    function automatic logic [31:0] model_status();
        int lvl;
        logic [31:0] s;
        lvl = model_q.size();
        s = 32'(lvl) << 8;
        if (m_ferr) s = s | 32'h8;
        if (m_ovr) s = s | 32'h4;
        if (lvl == DEPTH) s = s | 32'h2;
        if (lvl != 0) s = s | 32'h1;
        return s;
    endfunction

    function automatic logic [31:0] model_read_data();
        logic [7:0] b;
        if (model_q.size() == 0) return 32'h0;
        b = model_q.pop_front();
        return {23'b0, 1'b1, b};
    endfunction

    // One bus transfer; reports the ready latency (0 = never came) and
    // whether the pulse was exactly one cycle long with rdata back at 0.
    task automatic bus(input logic [3:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output logic [31:0] rdata,
                       output int lat, output bit one_pulse);
        @(negedge clk);
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_valid = 1'b1;
        lat = 0;
        rdata = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                lat = i;
                rdata = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = '0;
        @(posedge clk); #1;
        one_pulse = (lat != 0) && !mem_ready && (mem_rdata == 32'h0);
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_low_bits == 0) begin
            uart_rx = 1'b1;
            repeat (CPB) @(negedge clk);
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else m_ovr = 1;
        end else begin
            uart_rx = 1'b0;
            repeat (CPB * stop_low_bits) @(negedge clk);
            uart_rx = 1'b1;
            m_ferr = 1;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        bit pulse;
        repeat (3) @(negedge clk);
        total++;
        if ({mem_ready, mem_rdata, rx_irq} !== 34'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%0b rdata=%h irq=%0b want all 0",
                     mem_ready, mem_rdata, rx_irq);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        bus(4'h4, 32'h0, 4'h0, rd, lat, pulse);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL reset_status: got %h want %h", rd, 32'h0);
        end
        total++;
        if (lat !== 1 || !pulse) begin
            bad++; $display("FAIL reset_handshake_stat: got lat=%0d pulse=%0b want lat=1 pulse=1", lat, pulse);
        end
        bus(4'h0, 32'h0, 4'h0, rd, lat, pulse);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL reset_data: got %h want %h", rd, 32'h0);
        end
        total++;
        if (lat !== 1 || !pulse) begin
            bad++; $display("FAIL reset_handshake_data: got lat=%0d pulse=%0b want lat=1 pulse=1", lat, pulse);
        end
        total++;
        if (rx_irq !== 1'b0) begin
            bad++; $display("FAIL reset_irq: got %0b want 0", rx_irq);
        end
    endtask

    task automatic test_two_bytes();
        logic [31:0] rd, exp;
        int lat;
        bit pulse, proto_ok;
        proto_ok = 1;
        send_frame(8'hA5, 0);
        send_frame(8'h3C, 0);
        total++;
        if (rx_irq !== 1'b1) begin
            bad++; $display("FAIL two_irq_high: got %0b want 1", rx_irq);
        end
        exp = model_status();
        bus(4'h4, 32'h0, 4'h0, rd, lat, pulse);
        proto_ok &= (lat == 1) && pulse;
        total++;
        if (rd !== exp || rd[12:8] !== 5'd2) begin
            bad++; $display("FAIL two_status: got %h want %h (level 2)", rd, exp);
        end
        for (int i = 0; i < 3; i++) begin
            exp = model_read_data();
            bus(4'h0, 32'h0, 4'h0, rd, lat, pulse);
            proto_ok &= (lat == 1) && pulse;
            total++;
            if (rd !== exp) begin
                bad++; $display("FAIL two_read%0d: got %h want %h", i, rd, exp);
            end
        end
        repeat (2) @(negedge clk);
        total++;
        if (rx_irq !== 1'b0) begin
            bad++; $display("FAIL two_irq_low: got %0b want 0", rx_irq);
        end
        total++;
        if (!proto_ok) begin
            bad++; $display("FAIL two_handshake: got irregular ready pulse want one pulse after 1 cycle");
        end
    endtask

    task automatic test_glitch();
        logic [31:0] rd, exp;
        int lat;
        bit pulse;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        exp = model_status();
        bus(4'h4, 32'h0, 4'h0, rd, lat, pulse);
        total++;
        if (rd !== exp) begin
            bad++; $display("FAIL glitch_status: got %h want %h", rd, exp);
        end
        // A proper frame right after shows the receiver went back to idle.
        send_frame(8'hC3, 0);
        exp = model_read_data();
        bus(4'h0, 32'h0, 4'h0, rd, lat, pulse);
        total++;
        if (rd !== exp) begin
            bad++; $display("FAIL glitch_next_frame: got %h want %h", rd, exp);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd, exp;
        int lat;
        bit pulse;
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 0);
        exp = model_status();
        bus(4'h4, 32'h0, 4'h0, rd, lat, pulse);
        total++;
        if (rd !== exp || rd[1] !== 1'b1 || rd[2] !== 1'b1) begin
            bad++; $display("FAIL ovf_status: got %h want %h (full, ovr)", rd, exp);
        end
        for (int i = 0; i < 16; i++) begin
            exp = model_read_data();
            bus(4'h0, 32'h0, 4'h0, rd, lat, pulse);
            total++;
            if (rd !== exp) begin
                bad++; $display("FAIL ovf_read%0d: got %h want %h", i, rd, exp);
            end
        end
        bus(4'h4, 32'h4, 4'h1, rd, lat, pulse);
        m_ovr = 0;
        exp = model_status();
        bus(4'h4, 32'h0, 4'h0, rd, lat, pulse);
        total++;
        if (rd !== exp) begin
            bad++; $display("FAIL ovf_clear: got %h want %h", rd, exp);
        end
    endtask

    task automatic test_frame_error();
        logic [31:0] rd, exp;
        int lat;
        bit pulse;
        send_frame(8'h55, 3);
        exp = model_status();
        bus(4'h4, 32'h0, 4'h0, rd, lat, pulse);
        total++;
        if (rd !== exp || rd[3] !== 1'b1) begin
            bad++; $display("FAIL ferr_status: got %h want %h", rd, exp);
        end
        total++;
        if (rx_irq !== 1'b0) begin
            bad++; $display("FAIL ferr_irq: got %0b want 0", rx_irq);
        end
        bus(4'h4, 32'h8, 4'h1, rd, lat, pulse);
        total++;
        if (lat !== 1 || !pulse) begin
            bad++; $display("FAIL ferr_w1c_ack: got lat=%0d pulse=%0b want lat=1 pulse=1", lat, pulse);
        end
        m_ferr = 0;
        exp = model_status();
        bus(4'h4, 32'h0, 4'h0, rd, lat, pulse);
        total++;
        if (rd !== exp) begin
            bad++; $display("FAIL ferr_clear: got %h want %h", rd, exp);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd, exp;
        int lat;
        bit pulse;
        send_frame(8'h77, 0);
        // Reset lands while a read request is pending: no ready may follow.
        @(negedge clk);
        mem_addr = 4'h0; mem_wstrb = 4'h0; mem_valid = 1'b1;
        #2 resetn = 1'b0;
        @(posedge clk); #1;
        total++;
        if (mem_ready !== 1'b0) begin
            bad++; $display("FAIL rst_txn_ready: got %0b want 0", mem_ready);
        end
        mem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_q.delete(); m_ovr = 0; m_ferr = 0;
        repeat (4) @(negedge clk);
        // Partial frame, then reset in the middle of the data bits.
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_rx = i[0];
            repeat (CPB) @(negedge clk);
        end
        resetn = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h81, 0);
        exp = model_status();
        bus(4'h4, 32'h0, 4'h0, rd, lat, pulse);
        total++;
        if (rd !== exp || rd[12:8] !== 5'd1) begin
            bad++; $display("FAIL rst_status: got %h want %h (level 1)", rd, exp);
        end
        for (int i = 0; i < 2; i++) begin
            exp = model_read_data();
            bus(4'h0, 32'h0, 4'h0, rd, lat, pulse);
            total++;
            if (rd !== exp) begin
                bad++; $display("FAIL rst_read%0d: got %h want %h", i, rd, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp;
        int lat;
        bit pulse;
        for (int n = 0; n < 28; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                send_frame(8'($urandom_range(0, 255)), 0);
            end else if ($urandom_range(0, 1) == 0) begin
                exp = model_read_data();
                bus(4'h0, 32'h0, 4'h0, rd, lat, pulse);
                total++;
                if (rd !== exp) begin
                    bad++; $display("FAIL rand_read%0d: got %h want %h", n, rd, exp);
                end
            end else begin
                exp = model_status();
                bus(4'h4, 32'h0, 4'h0, rd, lat, pulse);
                total++;
                if (rd !== exp) begin
                    bad++; $display("FAIL rand_status%0d: got %h want %h", n, rd, exp);
                end
            end
        end
        // Unused offsets: read zero, writes acked and harmless.
        bus(4'hC, 32'hFFFF_FFFF, 4'hF, rd, lat, pulse);
        bus(4'h8, 32'h0, 4'h0, rd, lat, pulse);
        total++;
        if (rd !== 32'h0 || lat !== 1) begin
            bad++; $display("FAIL rand_unused: got %h lat=%0d want 0 lat=1", rd, lat);
        end
        while (model_q.size() != 0) begin
            exp = model_read_data();
            bus(4'h0, 32'h0, 4'h0, rd, lat, pulse);
            total++;
            if (rd !== exp) begin
                bad++; $display("FAIL rand_drain: got %h want %h", rd, exp);
            end
        end
        bus(4'h4, 32'hC, 4'h1, rd, lat, pulse);
        m_ovr = 0; m_ferr = 0;
        exp = model_status();
        bus(4'h4, 32'h0, 4'h0, rd, lat, pulse);
        total++;
        if (rd !== exp) begin
            bad++; $display("FAIL rand_final_status: got %h want %h", rd, exp);
        end
    endtask

    initial begin
        test_reset();
        test_two_bytes();
        test_glitch();
        test_overflow();
        test_frame_error();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
UART receiver with a small receive FIFO and a PicoRV32-style native memory-bus responder. It is the receive counterpart of the existing transmit path. It samples the serial input, reconstructs 8N1 frames and buffers the received bytes. The CPU drains the buffer through two word registers in the 0x2000_0000 UART region, and decoding of that region is done at top level.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); must be >= 4.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
uart_rx  in  1  serial input, asynchronous to clk, idle high
mem_valid  in  1  request, already qualified by top-level address decode
mem_addr  in  4  byte offset in block; only bits [3:2] decoded
mem_wdata  in  32  write data
mem_wstrb  in  4  byte strobes; nonzero means write
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid while mem_ready=1
rx_irq  out  1  level interrupt: FIFO not empty

Behaviour:
- Reset values: mem_ready=0, mem_rdata=0, rx_irq=0, FIFO empty, both sticky flags 0, FSM=IDLE, synchronizer flops=1.
- Input synchronization: uart_rx passes through a 2-flop synchronizer. All decisions use the synced bit rx_s.
- Receive FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A single bit counter cnt and a 3-bit bit index idx drive it.
- IDLE: when rx_s=0, go to START and load cnt=CLKS_PER_BIT/2-1.
- START: when cnt=0, check rx_s. If rx_s=0, go to DATA with cnt=CLKS_PER_BIT-1 and idx=0. If rx_s=1, treat as a glitch and return to IDLE with nothing recorded.
- DATA: when cnt=0, shift rx_s into shreg LSB-first, reload cnt, increment idx. After idx=7 is sampled, go to STOP.
- STOP: when cnt=0, check rx_s.
  - rx_s=1: push the byte and go to IDLE. If the FIFO is full, drop the byte and set sticky ovr.
  - rx_s=0: drop the byte, set sticky ferr, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This stops a break condition from producing repeated frames.
- Timing: a byte is visible in the FIFO 2 synchronizer cycles plus about 9.5 bit-times after the start edge.
- Register map (32-bit):
  - 0x0 DATA, read. Returns {23'b0, valid, byte}. If the FIFO is not empty: valid=1, byte=head, and the read pops one entry. If empty: returns 0 with no pop.
  - 0x0 DATA, write: ignored, but still acked.
  - 0x4 STATUS, read: bit0 not_empty, bit1 full, bit2 ovr, bit3 ferr, bits[8+FIFO_AW:8] level (0..16), all other bits 0.
  - 0x4 STATUS, write with mem_wstrb[0]=1: W1C, where wdata bit2 clears ovr and bit3 clears ferr.
  - 0x8, 0xC: read 0, writes ignored, acked.
- Handshake:
  - On a cycle with mem_valid=1 and mem_ready=0, the block registers mem_ready=1 and mem_rdata on the next edge (1-cycle latency).
  - The next cycle forces mem_ready=0, so each transfer gets exactly one pulse and at most one pop.
  - The master holds address and data stable until it sees mem_ready.
  - mem_rdata returns to 0 when mem_ready is 0.
- Simultaneous events:
  - A push and a pop in the same cycle: both happen, level is unchanged; on a full FIFO the push succeeds because the pop frees a slot.
  - A push and a pop on an empty FIFO: the pop returns empty, and the push lands.
  - A sticky-flag set and a W1C clear in the same cycle: set wins.
- FIFO pointers: FIFO_AW+1 bits each, wrap naturally. full and empty are derived from the MSB compare.
- rx_irq = not_empty, registered.
- Reset asserted mid-frame or mid-transaction: everything clears immediately (asynchronous), any partial byte is discarded, and no mem_ready is issued.

Decomposition:
- Package uart_pkg holds:
  - register offsets REG_DATA=0x0 and REG_STAT=0x4;
  - STATUS bit positions;
  - the rx FSM state encoding;
  - the 8N1 frame constants (data bits 8, stop bits 1).
- One sub-module, sync_fifo: parameterized width 8 and depth 2**FIFO_AW, with push/pop/full/empty/level outputs and async active-low reset. FSM, register decode and handshake stay in the top module.

Test Plan:
- Reset then idle line, with CLKS_PER_BIT=8 for all tests -> read STATUS = 0x0000_0000; read DATA = 0x0000_0000; rx_irq=0; each access gets exactly one mem_ready pulse, one cycle after mem_valid.
- Send 0xA5 then 0x3C -> STATUS level=2, rx_irq=1; DATA reads return 0x1A5 then 0x13C; a third read returns 0x000 and rx_irq drops to 0.
- 3-cycle low glitch on uart_rx -> no push, ferr=0, FSM back in IDLE.
- Send 17 bytes 0x00..0x10 without reading -> full=1, ovr=1; 16 reads return 0x100..0x10F; write 0x4 to STATUS clears ovr.
- Frame 0x55 with stop bit held low for 3 bit-times -> no push, ferr=1, no further frames received until the line returns high; write 0x8 to STATUS clears ferr.
- Deassert resetn mid-DATA, then release and send 0x81 -> only 0x181 is read, level=1.
